// File: rtl/pulse_stretch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_stretch_pkg
// Description : Shared state encoding and counter sizing for pulse_stretch.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    // The counter must hold the larger of the two reload values.
    function automatic int ctr_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_stretch_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module      : cycle_timer
// Description : Loadable down-counter; done flags the last cycle (count 1).
// Revision    : 1.0 - initial release
// ============================================================================
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] r_count;

    // Stops at zero rather than wrapping so an idle timer stays quiet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (load)
            r_count <= load_val;
        else if (r_count != '0)
            r_count <= r_count - W'(1);
    end

    assign done = (r_count == W'(1));

endmodule
`default_nettype wire

// File: rtl/pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module      : pulse_stretch
// Description : Stretches single-cycle events into fixed LED pulses with a
//               forced off-gap; queued events replay back to back.
//               Optional sticky drop flag: PULSE_STRETCH_OVF_FLAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 12_500_000,
    parameter int PEND_W      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending
`ifdef PULSE_STRETCH_OVF_FLAG_EN
    ,
    output logic              ovf
`endif
);

    localparam int              CW         = ctr_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0]   C_HOLD     = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0]   C_GAP      = CW'(GAP_CYCLES);
    localparam logic [PEND_W-1:0] C_MAX_PEND = '1;

    state_t              r_state, w_next_state;
    logic [PEND_W-1:0]   r_pending, w_pending_next;
    logic                r_led;
    logic                w_start, w_load, w_done;
    logic [CW-1:0]       w_load_val;

    cycle_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .done     (w_done)
    );

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_load       = 1'b0;
        w_load_val   = C_HOLD;
        case (r_state)
            IDLE: if (trig) begin
                w_next_state = ON;
                w_start      = 1'b1;
                w_load       = 1'b1;
            end
            ON: if (w_done) begin
                w_next_state = GAP;
                w_load       = 1'b1;
                w_load_val   = C_GAP;
            end
            GAP: if (w_done) begin
                // A pulse queued or arriving on the terminal edge starts at once.
                if ((r_pending != '0) || trig) begin
                    w_next_state = ON;
                    w_start      = 1'b1;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // A start consumes one request; otherwise requests accumulate and saturate.
    always_comb begin
        w_pending_next = r_pending;
        if (w_start)
            w_pending_next = r_pending + PEND_W'(trig) - PEND_W'(1);
        else if (trig && (r_pending != C_MAX_PEND))
            w_pending_next = r_pending + PEND_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_led     <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_pending <= w_pending_next;
            r_led     <= (w_next_state == ON);
        end
    end

    assign led     = r_led;
    assign busy    = (r_state != IDLE);
    assign pending = r_pending;

`ifdef PULSE_STRETCH_OVF_FLAG_EN
    logic w_drop;
    logic r_ovf;

    assign w_drop = trig && !w_start && (r_pending == C_MAX_PEND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (w_drop)
            r_ovf <= 1'b1;
    end

    assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: doc/pulse_stretch.md
# pulse_stretch

Output-side companion to the switch debouncer. It converts single-cycle event pulses, such as a debounced press strobe, into human-visible fixed-width pulses on an LED pin. Each pulse has a guaranteed off-gap so back-to-back events stay distinguishable. Events that arrive while a pulse is being shown are counted in a saturating pending counter and replayed in order.

## Interface
- `HOLD_CYCLES`, default 25_000_000: LED on-time in clk cycles, ≥1 (0.5 s at 50 MHz).
- `GAP_CYCLES`, default 12_500_000: forced LED off-time after each pulse, ≥1.
- `PEND_W`, default 2: pending-counter width; MAX_PEND = 2^PEND_W−1.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `trig` in 1: event request, sampled every edge. Each high cycle counts as one event.
- `led` out 1: stretched pulse, active-high, driven directly from a flop.
- `busy` out 1: high whenever state ≠ IDLE.
- `pending` out PEND_W: queued events not yet shown.
- `ovf` out 1: sticky dropped-event flag. Present only with the macro.

## Operation
- States:
  - IDLE: led=0.
  - ON: led=1; counter counts HOLD_CYCLES.
  - GAP: led=0; counter counts GAP_CYCLES.
- IDLE→ON on an edge with trig=1.
- ON→GAP after the HOLD_CYCLES-th edge in ON.
- At the GAP_CYCLES-th edge in GAP:
  - →ON if pending>0 or trig=1.
  - →IDLE otherwise.
  - No idle cycle is inserted between queued pulses.
- Start event: any edge entering ON. It consumes one request, so pending' = pending + trig − 1. This is never negative, because a start requires pending+trig ≥ 1.
- Non-start edge: pending' = pending + trig, saturating at MAX_PEND.
- Trig at MAX_PEND on a non-start edge: the event is dropped and pending holds.
- pending is 0 whenever state=IDLE.
- Counter width: $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1). It reloads on every state entry and never wraps.

## Timing
- Reset values: state IDLE, led 0, busy 0, pending 0, counter 0, ovf 0. On assertion these take effect immediately, mid-pulse included; queued events are discarded.
- trig sampled high at edge k from IDLE: led=1 after edge k through edge k+HOLD_CYCLES−1, led=0 after edge k+HOLD_CYCLES.
- After that pulse:
  - If nothing is queued, busy falls after edge k+HOLD_CYCLES+GAP_CYCLES.
  - If another request is queued, the next pulse rises after that same edge.
  - Pulse period is exactly HOLD_CYCLES+GAP_CYCLES.
- Input-to-led latency from IDLE is 1 edge. No combinational path exists from trig to any output.
- trig is assumed synchronous to clk; the upstream debouncer guarantees this.

## Configuration
- Macro: `PULSE_STRETCH_OVF_FLAG_EN`.
- Defined: port `ovf` exists. It is set on any dropped event, stays set until rst, and a drop and set in the same edge are both honoured.
- Undefined: no `ovf` port and no flop. Drops are silent; all other behaviour is identical.

## Structure
- Package `pulse_stretch_pkg`:
  - `state_t` enum {IDLE, ON, GAP}.
  - Helper function for the counter width.
- One sub-module, `cycle_timer`:
  - Loadable down-counter with inputs `load`/`load_val` and a `done` flag at count 1.
  - Instantiated once; it is shared by ON and GAP.

## Test plan
Parameters: HOLD=4, GAP=2, PEND_W=2.
1. Single trig at edge 10 -> led high after edges 10–13, low after edge 14, busy low after edge 16, pending 0 throughout.
2. trig at edges 10, 11, 12 -> pending 1 then 2. led pulses rise after edges 10, 16 and 22, each 4 cycles wide; pending reaches 0 at edge 22; busy low after edge 28.
3. trig high for edges 10–14 -> pending saturates at 3 at edge 13 and the edge-14 event is dropped. ovf=1 after edge 14 (macro on); exactly 4 pulses result.
4. trig at edge 10 and again at edge 16, the GAP terminal edge, with pending 0 -> led rises after edge 16 with no IDLE cycle; pending stays 0.
5. Simultaneous start and trig: pending=1 at GAP terminal edge 16 with trig=1 -> next pulse starts and pending stays 1.
6. rst asserted mid-ON at an arbitrary phase -> led, busy, pending and ovf go to 0 immediately. After release, one trig gives a normal 4-cycle pulse.
